fifo_out: RTL and testbench
===========================

Name: fifo_out

Overview:
- Output/status stage of the 8-entry FIFO.
- Takes the FIFO controller's current state code and occupancy count, and produces registered status flags (full, empty) and per-operation handshake strobes (write/read acknowledge and error).
- Sits between the FIFO next-state/count logic and the FIFO's external interface.
- Purely a decode-and-register stage: it holds no data storage.

Parameters:
- DEPTH, 8, FIFO capacity in entries; count value meaning "full".
- CNT_W, 4, width of data_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- state  input  3  FIFO controller state code.
- data_count  input  CNT_W  current FIFO occupancy.
- full  output  1  FIFO full flag.
- empty  output  1  FIFO empty flag.
- wr_ack  output  1  write accepted this cycle.
- wr_err  output  1  write rejected (FIFO was full).
- rd_ack  output  1  read accepted this cycle.
- rd_err  output  1  read rejected (FIFO was empty).

Behaviour:
- State encoding is shared with the controller:
  - INIT = 3'b000
  - READ = 3'b001
  - WRITE = 3'b010
  - RD_ERROR = 3'b011
  - WR_ERROR = 3'b100
  - NO_OP = 3'b101
  - 3'b110 and 3'b111 are unused.
- All six outputs are registered: sampled on the rising clk edge and valid one cycle after the inputs, so latency is 1 cycle. No combinational path from input to output.
- Reset (rst=1 at a rising edge) gives full=0, empty=1, wr_ack=0, wr_err=0, rd_ack=0, rd_err=0.
  - Reset has priority over all other inputs.
  - Asserting reset mid-operation discards the pending decode; outputs take reset values at that edge.
- Status flags depend only on data_count, independent of state:
  - empty_next = (data_count == 0).
  - full_next = (data_count >= DEPTH). Count values above DEPTH are illegal but are treated as full.
  - 1..DEPTH-1 gives full=0, empty=0.
- Handshake strobes depend only on state, independent of data_count:
  - READ: rd_ack=1, all others 0.
  - WRITE: wr_ack=1, all others 0.
  - RD_ERROR: rd_err=1, all others 0.
  - WR_ERROR: wr_err=1, all others 0.
  - INIT, NO_OP, 3'b110, 3'b111: all four strobes 0.
- At most one of wr_ack/wr_err/rd_ack/rd_err is high in any cycle (one-hot-or-zero).
- Strobes are level outputs mirroring the registered state. A state held for N cycles produces a strobe N cycles long; there is no pulse-shortening.
- Flags and strobes are independent. For example, state=WRITE with data_count=8 gives wr_ack=1 and full=1; consistency is the controller's job.
- Unknown/X on inputs is not handled specially.

Decomposition:
- Shared package fifo_pkg holds:
  - the state localparams INIT, READ, WRITE, RD_ERROR, WR_ERROR, NO_OP;
  - the state width (3);
  - DEPTH and CNT_W defaults.
- Reuse this package in the FIFO controller and in the bench.
- No sub-module: one combinational decode block feeding one output register block.
- Optional: include a simulation-only assertion that the four strobes stay one-hot-or-zero.

Test Plan:
- Reset: hold rst=1 for 2 cycles with state=WRITE, data_count=8 -> full=0, empty=1, all strobes 0. Release rst -> next edge gives wr_ack=1, full=1.
- INIT sweep: state=INIT with data_count 0, 5, 8 (one value per cycle) -> one cycle later {full,empty} = 01, 00, 10 respectively; all strobes 0 throughout.
- READ and WRITE sweeps: same count sweep -> rd_ack=1 (READ) or wr_ack=1 (WRITE) every cycle, others 0; flags follow count as in the INIT sweep.
- Error states: RD_ERROR and WR_ERROR, each swept over count 0, 5, 8 -> rd_err=1 or wr_err=1 respectively, other strobes 0, flags follow count.
- NO_OP and unused codes: state=NO_OP, 3'b110, 3'b111 with count 0, 5, 8 -> all strobes 0, flags follow count. Also count=12 -> full=1, empty=0.
- Latency and mid-run reset: change state every cycle READ -> WRITE -> RD_ERROR -> each strobe appears exactly 1 cycle after its input. Assert rst during the WRITE cycle -> the next output is the reset values, not wr_ack.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: controller state codes, state width and default geometry.
// The controller, the output stage and the bench all import this package.
package fifo_pkg;

   localparam int unsigned STATE_W    = 3;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned FIFO_CNT_W = 4;

   // Codes 3'b110 and 3'b111 are unused and decode as idle.
   typedef enum logic [STATE_W-1:0] {
      INIT     = 3'b000,
      READ     = 3'b001,
      WRITE    = 3'b010,
      RD_ERROR = 3'b011,
      WR_ERROR = 3'b100,
      NO_OP    = 3'b101
   } fifo_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_out.sv
// FIFO output/status stage: decodes controller state and occupancy into
// registered full/empty flags and one-hot-or-zero handshake strobes.
module fifo_out
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned CNT_W = FIFO_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] state,
   input  logic [CNT_W-1:0]   data_count,
   output logic               full,
   output logic               empty,
   output logic               wr_ack,
   output logic               wr_err,
   output logic               rd_ack,
   output logic               rd_err
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic w_full;
   logic w_empty;
   logic w_wr_ack;
   logic w_wr_err;
   logic w_rd_ack;
   logic w_rd_err;

   logic r_full;
   logic r_empty;
   logic r_wr_ack;
   logic r_wr_err;
   logic r_rd_ack;
   logic r_rd_err;

   // Flags follow occupancy only; counts above DEPTH are illegal but read as full.
   always_comb begin
      w_full  = (data_count >= DEPTH_CNT);
      w_empty = (data_count == '0);
   end

   always_comb begin
      w_wr_ack = 1'b0;
      w_wr_err = 1'b0;
      w_rd_ack = 1'b0;
      w_rd_err = 1'b0;
      case (state)
         READ:     w_rd_ack = 1'b1;
         WRITE:    w_wr_ack = 1'b1;
         RD_ERROR: w_rd_err = 1'b1;
         WR_ERROR: w_wr_err = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_wr_ack <= 1'b0;
         r_wr_err <= 1'b0;
         r_rd_ack <= 1'b0;
         r_rd_err <= 1'b0;
      end else begin
         r_full   <= w_full;
         r_empty  <= w_empty;
         r_wr_ack <= w_wr_ack;
         r_wr_err <= w_wr_err;
         r_rd_ack <= w_rd_ack;
         r_rd_err <= w_rd_err;
      end
   end

   always_ff @(posedge clk) begin
      assert ($onehot0({r_wr_ack, r_wr_err, r_rd_ack, r_rd_err}));
   end

   assign full   = r_full;
   assign empty  = r_empty;
   assign wr_ack = r_wr_ack;
   assign wr_err = r_wr_err;
   assign rd_ack = r_rd_ack;
   assign rd_err = r_rd_err;

endmodule : fifo_out

// File: tb/tb_fifo_out.sv
// Randomised and directed bench for fifo_out against a table-driven reference model.
module tb_fifo_out;
   import fifo_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] state;
   logic [3:0] data_count;
   logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [5:0]  prev_exp;
   logic        have_prev = 1'b0;

   // Strobe table indexed by state code, bits {wr_ack, wr_err, rd_ack, rd_err}.
   logic [3:0] strobe_tbl [8];

   fifo_out #(.DEPTH(8), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%b exp=%b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] model(input logic r, input int unsigned st, input int unsigned cnt);
      logic [1:0] flags;
      if (r) return 6'b01_0000;
      flags = {cnt >= 8, cnt == 0};
      return {flags, strobe_tbl[st]};
   endfunction

   task automatic step(input string tag, input logic r, input logic [2:0] st, input logic [3:0] cnt);
      logic [5:0] exp;
      rst        = r;
      state      = st;
      data_count = cnt;
      #1;
      if (have_prev)
         check_eq({tag, "/hold"}, {2'b0, full, empty, wr_ack, wr_err, rd_ack, rd_err}, {2'b0, prev_exp});
      @(posedge clk);
      #1;
      exp = model(r, int'(st), int'(cnt));
      check_eq({tag, "/flags"}, {6'b0, full, empty}, {6'b0, exp[5:4]});
      check_eq({tag, "/strobes"}, {4'b0, wr_ack, wr_err, rd_ack, rd_err}, {4'b0, exp[3:0]});
      prev_exp  = exp;
      have_prev = 1'b1;
   endtask

   initial begin
      logic [3:0] sweep [3];
      logic [2:0] codes [8];
      strobe_tbl[0] = 4'b0000;
      strobe_tbl[1] = 4'b0010;
      strobe_tbl[2] = 4'b1000;
      strobe_tbl[3] = 4'b0001;
      strobe_tbl[4] = 4'b0100;
      strobe_tbl[5] = 4'b0000;
      strobe_tbl[6] = 4'b0000;
      strobe_tbl[7] = 4'b0000;
      sweep[0] = 4'd0;
      sweep[1] = 4'd5;
      sweep[2] = 4'd8;
      codes[0] = INIT;
      codes[1] = READ;
      codes[2] = WRITE;
      codes[3] = RD_ERROR;
      codes[4] = WR_ERROR;
      codes[5] = NO_OP;
      codes[6] = 3'b110;
      codes[7] = 3'b111;

      step("reset0", 1'b1, WRITE, 4'd8);
      step("reset1", 1'b1, WRITE, 4'd8);
      step("release", 1'b0, WRITE, 4'd8);

      for (int s = 0; s < 8; s++)
         for (int c = 0; c < 3; c++)
            step($sformatf("sweep_s%0d_c%0d", codes[s], sweep[c]), 1'b0, codes[s], sweep[c]);

      step("over12", 1'b0, NO_OP, 4'd12);
      step("over15", 1'b0, 3'b111, 4'd15);
      step("cnt7", 1'b0, READ, 4'd7);
      step("cnt1", 1'b0, WR_ERROR, 4'd1);

      step("lat_rd", 1'b0, READ, 4'd3);
      step("lat_wr", 1'b0, WRITE, 4'd3);
      step("lat_re", 1'b0, RD_ERROR, 4'd3);
      step("mid_rd", 1'b0, READ, 4'd4);
      step("mid_rst", 1'b1, WRITE, 4'd4);
      step("mid_after", 1'b0, RD_ERROR, 4'd4);
      step("hold_wr0", 1'b0, WRITE, 4'd2);
      step("hold_wr1", 1'b0, WRITE, 4'd2);
      step("hold_wr2", 1'b0, WRITE, 4'd2);

      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_fifo_out
